// File: rtl/sr_ff_from_jk_bank.sv
// Bank of SR flip-flops built on JK cores, with S=R=1 detection, fault/lock FSM
// and a saturating illegal-event counter (counter present only with SR_FF_ERR_CNT_EN).
module sr_ff_from_jk_bank #(
  parameter int WIDTH          = 4,
  parameter int CNT_W          = 8,
  parameter int ILLEGAL_POLICY = 0,
  parameter int LOCK_THRESH    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic             clr_err,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qb,
  output logic [WIDTH-1:0] illegal,
  output logic             err_sticky,
  output logic             locked,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0] ST_NORMAL = 2'd0;
  localparam logic [1:0] ST_FAULT  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  localparam logic [3:0] THRESH    = 4'(LOCK_THRESH);

  logic [WIDTH-1:0] sr_ill;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q_next;
  logic             any_ill;
  logic [1:0]       state;
  logic [3:0]       consec;
  logic [3:0]       consec_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Legal bits drive J=S, K=R; illegal bits get J/K from the resolution policy.
  always_comb begin
    sr_ill = S & R;
    j      = S & ~sr_ill;
    k      = R & ~sr_ill;
    case (ILLEGAL_POLICY)
      1:       j = S;
      2:       k = R;
      3:       begin j = S; k = R; end
      default: ;
    endcase
  end

  assign q_next     = (j & ~Q) | (~k & Q);
  assign any_ill    = (|sr_ill) & en;
  assign consec_inc = consec + 4'd1;
  assign Qb         = ~Q;
  assign locked     = (state == ST_LOCKED);

  // JK core: state at the edge decides whether Q is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Q       <= '0;
      illegal <= '0;
    end else if (en) begin
      illegal <= sr_ill;
      if (state != ST_LOCKED) Q <= q_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_NORMAL;
      consec     <= 4'd0;
      err_sticky <= 1'b0;
    end else if (clr_err) begin
      state      <= ST_NORMAL;
      consec     <= 4'd0;
      err_sticky <= 1'b0;
    end else begin
      if (any_ill) err_sticky <= 1'b1;
      case (state)
        ST_NORMAL: begin
          if (any_ill) begin
            consec <= 4'd1;
            state  <= (THRESH <= 4'd1) ? ST_LOCKED : ST_FAULT;
          end
        end
        ST_FAULT: begin
          if (any_ill) begin
            consec <= consec_inc;
            if (consec_inc >= THRESH) state <= ST_LOCKED;
          end else if (en) begin
            consec <= 4'd0;
          end
        end
        ST_LOCKED: ;
        default: state <= ST_NORMAL;
      endcase
    end
  end

`ifdef SR_FF_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_cnt <= '0;
    else if (clr_err) err_cnt <= '0;
    else if (any_ill) err_cnt <= sat_inc(err_cnt);
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_sr_ff_from_jk_bank.sv
// Directed bench for sr_ff_from_jk_bank: one instance per illegal policy plus a
// narrow-counter instance for saturation; err_cnt expectations follow SR_FF_ERR_CNT_EN.
module tb_sr_ff_from_jk_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] S = '0;
  logic [3:0] R = '0;
  logic       clr_err = 1'b0;

  logic [3:0] q_p   [4];
  logic [3:0] qb_p  [4];
  logic [3:0] ill_p [4];
  logic       st_p  [4];
  logic       lk_p  [4];
  logic [7:0] cnt_p [4];

  logic [3:0] q_s, qb_s, ill_s;
  logic       st_s, lk_s;
  logic [1:0] cnt_s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_pol
    sr_ff_from_jk_bank #(.WIDTH(4), .CNT_W(8), .ILLEGAL_POLICY(g), .LOCK_THRESH(3)) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .S(S), .R(R), .clr_err(clr_err),
      .Q(q_p[g]), .Qb(qb_p[g]), .illegal(ill_p[g]), .err_sticky(st_p[g]),
      .locked(lk_p[g]), .err_cnt(cnt_p[g])
    );
  end

  sr_ff_from_jk_bank #(.WIDTH(4), .CNT_W(2), .ILLEGAL_POLICY(0), .LOCK_THRESH(15)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .S(S), .R(R), .clr_err(clr_err),
    .Q(q_s), .Qb(qb_s), .illegal(ill_s), .err_sticky(st_s),
    .locked(lk_s), .err_cnt(cnt_s)
  );

  typedef struct {
    logic       en;
    logic [3:0] s;
    logic [3:0] r;
    logic       clr;
    logic [3:0] q;
    logic [3:0] ill;
    logic       st;
    logic       lk;
    int         cnt;
  } vec_t;

  vec_t vt[25];

  function automatic int ec(input int v);
`ifdef SR_FF_ERR_CNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic [3:0] s, input logic [3:0] r, input logic c);
    @(negedge clk);
    en = e; S = s; R = r; clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0; S = '0; R = '0; clr_err = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //           en    S        R        clr   Q        ill      st    lk    cnt
    vt[0]  = '{1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 0};
    vt[1]  = '{1'b1, 4'b0100, 4'b0000, 1'b0, 4'b0101, 4'b0000, 1'b0, 1'b0, 0};
    vt[2]  = '{1'b1, 4'b0000, 4'b0001, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0, 0};
    vt[3]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0, 0};
    vt[4]  = '{1'b0, 4'b0011, 4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0, 0};
    vt[5]  = '{1'b1, 4'b1000, 4'b1000, 1'b0, 4'b0100, 4'b1000, 1'b1, 1'b0, 1};
    vt[6]  = '{1'b1, 4'b1010, 4'b1000, 1'b0, 4'b0110, 4'b1000, 1'b1, 1'b0, 2};
    vt[7]  = '{1'b0, 4'b1000, 4'b1000, 1'b0, 4'b0110, 4'b1000, 1'b1, 1'b0, 2};
    vt[8]  = '{1'b1, 4'b1000, 4'b1000, 1'b0, 4'b0110, 4'b1000, 1'b1, 1'b1, 3};
    vt[9]  = '{1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0110, 4'b0000, 1'b1, 1'b1, 3};
    vt[10] = '{1'b1, 4'b1000, 4'b1000, 1'b0, 4'b0110, 4'b1000, 1'b1, 1'b1, 4};
    vt[11] = '{1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0110, 4'b0000, 1'b0, 1'b0, 0};
    vt[12] = '{1'b1, 4'b0001, 4'b0100, 1'b0, 4'b0011, 4'b0000, 1'b0, 1'b0, 0};
    vt[13] = '{1'b1, 4'b0001, 4'b0001, 1'b0, 4'b0011, 4'b0001, 1'b1, 1'b0, 1};
    vt[14] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0011, 4'b0000, 1'b1, 1'b0, 1};
    vt[15] = '{1'b1, 4'b0100, 4'b0100, 1'b0, 4'b0011, 4'b0100, 1'b1, 1'b0, 2};
    vt[16] = '{1'b1, 4'b0000, 4'b0010, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 2};
    vt[17] = '{1'b1, 4'b0001, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0, 3};
    vt[18] = '{1'b1, 4'b1000, 4'b1000, 1'b1, 4'b0001, 4'b1000, 1'b0, 1'b0, 0};
    vt[19] = '{1'b1, 4'b1000, 4'b1000, 1'b0, 4'b0001, 4'b1000, 1'b1, 1'b0, 1};
    vt[20] = '{1'b1, 4'b1000, 4'b1000, 1'b0, 4'b0001, 4'b1000, 1'b1, 1'b0, 2};
    vt[21] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 2};
    vt[22] = '{1'b1, 4'b1000, 4'b1000, 1'b0, 4'b0001, 4'b1000, 1'b1, 1'b0, 3};
    vt[23] = '{1'b1, 4'b1000, 4'b1000, 1'b0, 4'b0001, 4'b1000, 1'b1, 1'b0, 4};
    vt[24] = '{1'b1, 4'b1000, 4'b1000, 1'b0, 4'b0001, 4'b1000, 1'b1, 1'b1, 5};

    // Reset state of every instance
    #12;
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("rst_q_p%0d", p), q_p[p], 0);
      chk($sformatf("rst_qb_p%0d", p), qb_p[p], 4'hf);
      chk($sformatf("rst_ill_p%0d", p), ill_p[p], 0);
      chk($sformatf("rst_lk_p%0d", p), lk_p[p], 0);
      chk($sformatf("rst_cnt_p%0d", p), cnt_p[p], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Policy sweep: Q[0]=1, then S[0]=R[0]=1 twice
    step(1'b1, 4'b0001, 4'b0000, 1'b0);
    for (int p = 0; p < 4; p++) chk($sformatf("sweep_set_q_p%0d", p), q_p[p], 4'b0001);
    step(1'b1, 4'b0001, 4'b0001, 1'b0);
    chk("sweep1_q_p0", q_p[0], 4'b0001);
    chk("sweep1_q_p1", q_p[1], 4'b0001);
    chk("sweep1_q_p2", q_p[2], 4'b0000);
    chk("sweep1_q_p3", q_p[3], 4'b0000);
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("sweep1_ill_p%0d", p), ill_p[p], 4'b0001);
      chk($sformatf("sweep1_st_p%0d", p), st_p[p], 1);
      chk($sformatf("sweep1_cnt_p%0d", p), cnt_p[p], ec(1));
    end
    step(1'b1, 4'b0001, 4'b0001, 1'b0);
    chk("sweep2_q_p0", q_p[0], 4'b0001);
    chk("sweep2_q_p2", q_p[2], 4'b0000);
    chk("sweep2_q_p3", q_p[3], 4'b0001);
    chk("sweep2_lk_p3", lk_p[3], 0);

    // Table-driven sequence on the policy-0 instance
    do_reset();
    for (int i = 0; i < 25; i++) begin
      step(vt[i].en, vt[i].s, vt[i].r, vt[i].clr);
      chk($sformatf("vec%0d_q", i), q_p[0], vt[i].q);
      chk($sformatf("vec%0d_qb", i), qb_p[0], ~vt[i].q & 4'hf);
      chk($sformatf("vec%0d_ill", i), ill_p[0], vt[i].ill);
      chk($sformatf("vec%0d_st", i), st_p[0], vt[i].st);
      chk($sformatf("vec%0d_lk", i), lk_p[0], vt[i].lk);
      chk($sformatf("vec%0d_cnt", i), cnt_p[0], ec(vt[i].cnt));
    end

    // Saturation on the 2-bit counter instance; main instance locks on the 3rd edge
    do_reset();
    step(1'b1, 4'b0011, 4'b0000, 1'b0);
    for (int n = 1; n <= 5; n++) begin
      step(1'b1, 4'b1000, 4'b1000, 1'b0);
      chk($sformatf("sat%0d_cnt", n), cnt_s, ec(n > 3 ? 3 : n));
      chk($sformatf("sat%0d_lk", n), lk_s, 0);
      chk($sformatf("sat%0d_main_lk", n), lk_p[0], n >= 3 ? 1 : 0);
    end
    step(1'b1, 4'b0000, 4'b0000, 1'b1);
    chk("sat_clr_cnt", cnt_s, 0);
    chk("sat_clr_main_lk", lk_p[0], 0);
    step(1'b1, 4'b0000, 4'b0000, 1'b0);
    for (int n = 1; n <= 3; n++) step(1'b1, 4'b1000, 4'b1000, 1'b0);
    chk("relock_lk", lk_p[0], 1);
    chk("relock_q", q_p[0], 4'b0011);
    chk("relock_cnt_sat", cnt_s, ec(3));

    // Asynchronous reset between edges while LOCKED and en=0
    en = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_q", q_p[0], 0);
    chk("async_qb", qb_p[0], 4'hf);
    chk("async_lk", lk_p[0], 0);
    chk("async_st", st_p[0], 0);
    chk("async_ill", ill_p[0], 0);
    chk("async_cnt", cnt_p[0], 0);
    chk("async_sat_cnt", cnt_s, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 4'b0010, 4'b0000, 1'b0);
    chk("post_rst_q", q_p[0], 4'b0010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sr_ff_from_jk_bank.md
Name: sr_ff_from_jk_bank

Overview:
- Bank of WIDTH SR flip-flops, each built on an internal JK flip-flop core. This is the JK-to-SR conversion, the reverse of the SR-to-JK conversion.
- Adds detection of the forbidden S=R=1 input, a policy for resolving it, a fault/lock state machine and an illegal-event counter.
- Sits in the flip-flop conversion series. It is the SR-facing end used by the control logic and benches in that series.

Parameters:
- WIDTH, 4: number of SR bits in the bank.
- CNT_W, 8: width of the illegal-event counter.
- ILLEGAL_POLICY, 0: resolution of S=R=1 on a bit. 0 = hold, 1 = force set, 2 = force reset, 3 = toggle (raw JK behaviour).
- LOCK_THRESH, 3: consecutive enabled cycles with any illegal bit that move FAULT to LOCKED. Legal range is 1..15.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- en, input, 1: update enable; when 0, Q holds and no checks are made.
- S, input, WIDTH: per-bit set inputs.
- R, input, WIDTH: per-bit reset inputs.
- clr_err, input, 1: synchronous clear of the fault state, sticky flag and counter.
- Q, output, WIDTH: flip-flop outputs.
- Qb, output, WIDTH: complement of Q, combinational.
- illegal, output, WIDTH: registered per-bit S&R seen on the last enabled edge.
- err_sticky, output, 1: set on any illegal event; held until clr_err.
- locked, output, 1: high while the FSM is in LOCKED.
- err_cnt, output, CNT_W: saturating count of enabled cycles with any illegal bit.

Behaviour:
- Reset (rst_n=0, asynchronous): Q=0, Qb=all 1s, illegal=0, err_sticky=0, err_cnt=0, FSM=NORMAL, consecutive counter=0. Reset overrides everything at any time, including in LOCKED.
- Per-bit JK drive: J=S, K=R when S&R=0.
- When S=R=1, J/K follow ILLEGAL_POLICY:
  - hold: J=0, K=0.
  - set: J=1, K=0.
  - reset: J=0, K=1.
  - toggle: J=1, K=1.
- JK core: Q+ = J&~Q | ~K&Q. Q updates one cycle after inputs are sampled (latency 1).
- Effective SR truth table:
  - 00: hold.
  - 10: Q=1.
  - 01: Q=0.
  - 11: per policy.
- en=0: Q, illegal, counters and FSM all hold. S/R are ignored.
- illegal register: loaded with S&R on every enabled edge, so it clears on the next enabled edge with legal inputs.
- any_ill = |(S&R) & en.
- FSM states NORMAL, FAULT, LOCKED. Transitions are evaluated at each edge:
  - NORMAL: any_ill goes to FAULT, sets err_sticky, consec=1. If LOCK_THRESH=1, it goes to LOCKED directly.
  - FAULT: any_ill increments consec. When consec reaches LOCK_THRESH, go to LOCKED. An enabled legal cycle resets consec to 0 and stays in FAULT. en=0 holds consec.
  - LOCKED: Q is frozen regardless of en/S/R. illegal is still updated and err_cnt still counts. locked=1.
  - Any state with clr_err=1: go to NORMAL, err_sticky=0, err_cnt=0, consec=0.
  - clr_err wins over a simultaneous any_ill. The illegal register still loads that cycle, and Q updates per policy unless the FSM was LOCKED at that edge.
- consec is a 4-bit counter.
- err_cnt: +1 per any_ill edge, saturating at 2^CNT_W-1 with no wrap.
- Bits are independent. A legal bit updates normally in the same cycle another bit is illegal, except in LOCKED.

Optional Feature:
- Macro: SR_FF_ERR_CNT_EN.
- Defined: err_cnt is implemented as specified.
- Not defined: the counter logic is removed and err_cnt is tied to 0. All other behaviour is unchanged.

Test Plan:
- Reset then legal ops, WIDTH=4, policy 0: S=4'b0001,R=0 → Q=4'b0001 next edge. Then S=0,R=4'b0001 → Q=0. Then S=R=0 → Q holds. illegal stays 0 and err_sticky stays 0 throughout.
- Policy sweep with Q[0]=1 and S[0]=R[0]=1 for one edge:
  - policy 0: Q[0]=1.
  - policy 1: Q[0]=1.
  - policy 2: Q[0]=0.
  - policy 3: Q[0]=0. A second edge toggles it back to 1.
  - In every case illegal[0]=1, err_sticky=1, err_cnt=1.
- Lock, LOCK_THRESH=3: three consecutive enabled S=R=4'b1000 cycles → locked=1 after the 3rd edge. Then S=4'b0010 → Q unchanged. err_cnt=3 plus one per further illegal edge. clr_err=1 → locked=0, err_cnt=0, and S=4'b0010 sets Q[1] on the following edge.
- Non-consecutive: illegal, legal, illegal, legal edges → stays in FAULT, locked=0, err_cnt=2.
- Saturation, CNT_W=2: 5 illegal edges with clr_err pulsed before lock → counter reads 3 without wrapping. Also run with SR_FF_ERR_CNT_EN undefined → err_cnt=0 throughout.
- Async reset mid-LOCKED and with en=0: rst_n low between edges → all outputs return to reset values immediately (Q=0, Qb=4'b1111, locked=0), without waiting for a clock edge.
